carfield_reg_apb_demux: RTL and testbench
=========================================

// Module: carfield_reg_apb_demux
// PURPOSE
// Regbus-to-APB bridge with 1:N demux for the carfield APB peripherals: SystemTimer, AdvancedTimer, SystemWdt, CAN, HyperBus.
// Sits downstream of the Periphs external AXI slave (after its AXI-to-regbus conversion) and drives one APB3 select per peripheral.
// Decodes with the carfield_pkg apb_start_t/apb_end_t map. Runs one transaction at a time through a registered FSM.
// PARAMETERS
// AddrWidth      32    regbus/APB address width (carfield_a32_d32_reg)
// DataWidth      32    regbus/APB data width; strobe width = DataWidth/8
// NumApbMst      5     number of APB targets; index = carfield_peripherals_e
// TimeoutCycles  256   max ACCESS cycles before forced error (timeout build only); must be >= 2
// PORTS
// clk_i          in   1                    clock
// rst_ni         in   1                    asynchronous active-low reset
// reg_valid_i    in   1                    regbus request valid
// reg_write_i    in   1                    1 = write, 0 = read
// reg_addr_i     in   AddrWidth            byte address
// reg_wdata_i    in   DataWidth            write data
// reg_wstrb_i    in   DataWidth/8          write byte strobes
// reg_ready_o    out  1                    response valid / request consumed (1-cycle pulse)
// reg_rdata_o    out  DataWidth            read data, valid while reg_ready_o
// reg_error_o    out  1                    decode miss, PSLVERR or timeout, valid while reg_ready_o
// apb_psel_o     out  NumApbMst            one-hot select
// apb_penable_o  out  1                    shared APB enable
// apb_pwrite_o   out  1                    shared write flag
// apb_paddr_o    out  AddrWidth            shared, full unmodified address
// apb_pwdata_o   out  DataWidth            shared write data
// apb_pstrb_o    out  DataWidth/8          shared strobes; forced 0 on reads
// apb_pprot_o    out  3                    tied 3'b000
// apb_prdata_i   in   NumApbMst*DataWidth  per-target read data, slot i = [i*DataWidth +: DataWidth]
// apb_pready_i   in   NumApbMst            per-target ready
// apb_pslverr_i  in   NumApbMst            per-target error
// BEHAVIOUR
// - Map, hit iff start <= addr < end:
//   0 SystemTimer   [0x2000_4000, 0x2000_5000)
//   1 AdvTimer      [0x2000_5000, 0x2000_6000)
//   2 Wdt           [0x2000_7000, 0x2000_8000)
//   3 CAN           [0x2000_1000, 0x2000_2000)
//   4 HyperBus      [0x2000_9000, 0x2000_A000)
//   Lowest index wins on overlap (none today).
// - FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
//   Reset value of every output is 0; FSM resets to IDLE.
// - IDLE: on reg_valid_i, latch addr/wdata/wstrb/write and the decoded index.
//   Hit -> SETUP. Miss -> DONE with err=1, rdata=0; no APB activity.
// - SETUP (1 cycle): psel[idx]=1, penable=0 -> ACCESS.
// - ACCESS: psel[idx]=1, penable=1. Hold until pready_i[idx]=1.
//   Then capture prdata slot idx (0 on writes) and err=pslverr_i[idx] -> DONE.
//   pready/pslverr of non-selected targets are ignored.
// - DONE (1 cycle): reg_ready_o=1 with rdata/error; psel=0, penable=0 -> IDLE.
//   reg_valid_i is sampled again only in IDLE, so no request is lost or double-issued.
// - Latency with a zero-wait target: valid seen in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, ready in cycle 3.
//   Decode miss: ready in cycle 1. Back-to-back throughput is 1 transaction per 4 cycles.
// - Regbus contract: master holds its request stable until reg_ready_o; the block uses only latched values.
// - Reset asserted mid-transaction: immediate return to IDLE, all outputs 0. The aborted access gets no response.
// CONFIGURATION
// - CARFIELD_APB_TIMEOUT_EN defined:
//   - A $clog2(TimeoutCycles+1)-bit counter clears on entering ACCESS and increments each ACCESS cycle without pready.
//   - When it reaches TimeoutCycles: psel/penable drop -> DONE with err=1, rdata=0.
//   - pready arriving in that same cycle wins: normal completion.
// - Undefined: no counter; ACCESS waits indefinitely for pready.
// TESTING
// - Read 0x2000_4008, target 0 pready=1 first ACCESS cycle, prdata=0xCAFE_0001 -> psel=5'b00001, ready at cycle 3, rdata=0xCAFE_0001, err=0.
// - Write 0x2000_9010, wdata=0x1234_5678, wstrb=4'b0011, target 4 waits 3 cycles -> psel=5'b10000, pstrb=0011, ready at cycle 6, err=0.
// - Read 0x2000_6000 (gap) -> no psel ever asserted; ready at cycle 1 with err=1, rdata=0.
// - Read 0x2000_1FFC, target 3 pslverr=1 -> ready with err=1. Then read 0x2000_2000 -> decode miss.
// - Timeout build, target 2 never ready -> psel held exactly 256 ACCESS cycles, then ready with err=1. Non-timeout build: still waiting at cycle 1000.
// - rst_ni low during ACCESS -> next cycle all outputs 0, FSM in IDLE. A fresh read after reset completes normally.

Source files
------------

// File: rtl/carfield_reg_apb_demux.sv
// Regbus-to-APB3 bridge with a 1:N select demux for the carfield APB peripherals
// (SystemTimer, AdvancedTimer, SystemWdt, CAN, HyperBus). One transaction at a time.
// Optional ACCESS-phase timeout: define CARFIELD_APB_TIMEOUT_EN.
module carfield_reg_apb_demux #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NumApbMst     = 5,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           reg_valid_i,
    input  logic                           reg_write_i,
    input  logic [AddrWidth-1:0]           reg_addr_i,
    input  logic [DataWidth-1:0]           reg_wdata_i,
    input  logic [DataWidth/8-1:0]         reg_wstrb_i,
    output logic                           reg_ready_o,
    output logic [DataWidth-1:0]           reg_rdata_o,
    output logic                           reg_error_o,
    output logic [NumApbMst-1:0]           apb_psel_o,
    output logic                           apb_penable_o,
    output logic                           apb_pwrite_o,
    output logic [AddrWidth-1:0]           apb_paddr_o,
    output logic [DataWidth-1:0]           apb_pwdata_o,
    output logic [DataWidth/8-1:0]         apb_pstrb_o,
    output logic [2:0]                     apb_pprot_o,
    input  logic [NumApbMst*DataWidth-1:0] apb_prdata_i,
    input  logic [NumApbMst-1:0]           apb_pready_i,
    input  logic [NumApbMst-1:0]           apb_pslverr_i
);

    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam int unsigned IdxWidth   = (NumApbMst > 1) ? $clog2(NumApbMst) : 1;
    localparam int unsigned MapSize    = 5;
    localparam int unsigned MapEntries = (NumApbMst < MapSize) ? NumApbMst : MapSize;

    // Address map indexed by peripheral id: hit iff start <= addr < end.
    localparam logic [31:0] MapStart [MapSize] = '{
        32'h2000_4000, 32'h2000_5000, 32'h2000_7000, 32'h2000_1000, 32'h2000_9000
    };
    localparam logic [31:0] MapEnd [MapSize] = '{
        32'h2000_5000, 32'h2000_6000, 32'h2000_8000, 32'h2000_2000, 32'h2000_A000
    };

    // A timeout shorter than two cycles cannot distinguish a slow target from a dead one.
    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("TimeoutCycles must be >= 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDone
    } state_e;

    state_e                 state;
    logic [IdxWidth-1:0]    sel_idx;
    logic                   dec_hit;
    logic [IdxWidth-1:0]    dec_idx;
    logic [DataWidth-1:0]   prdata_slot [NumApbMst];
    logic [DataWidth-1:0]   sel_prdata;
    logic                   sel_pready;
    logic                   sel_pslverr;

`ifdef CARFIELD_APB_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0]    tmo_cnt;
`endif

    assign apb_pprot_o = 3'b000;

    // Split the flat read-data bus into per-target slots.
    for (genvar g = 0; g < NumApbMst; g++) begin : g_prdata_slot
        assign prdata_slot[g] = apb_prdata_i[g*DataWidth +: DataWidth];
    end

    // Response signals of the latched target only; everyone else is ignored.
    assign sel_prdata  = prdata_slot[sel_idx];
    assign sel_pready  = apb_pready_i[sel_idx];
    assign sel_pslverr = apb_pslverr_i[sel_idx];

    // Address decode; scanning downward lets the lowest index win on overlap.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = int'(MapEntries) - 1; i >= 0; i--) begin
            if ((reg_addr_i >= AddrWidth'(MapStart[i])) && (reg_addr_i < AddrWidth'(MapEnd[i]))) begin
                dec_hit = 1'b1;
                dec_idx = IdxWidth'(i);
            end
        end
    end

    // Transaction FSM with registered regbus response and APB request outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= StIdle;
            sel_idx       <= '0;
            reg_ready_o   <= 1'b0;
            reg_rdata_o   <= '0;
            reg_error_o   <= 1'b0;
            apb_psel_o    <= '0;
            apb_penable_o <= 1'b0;
            apb_pwrite_o  <= 1'b0;
            apb_paddr_o   <= '0;
            apb_pwdata_o  <= '0;
            apb_pstrb_o   <= '0;
`ifdef CARFIELD_APB_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (reg_valid_i) begin
                        if (dec_hit) begin
                            state        <= StSetup;
                            sel_idx      <= dec_idx;
                            apb_psel_o   <= NumApbMst'(1) << dec_idx;
                            apb_pwrite_o <= reg_write_i;
                            apb_paddr_o  <= reg_addr_i;
                            apb_pwdata_o <= reg_wdata_i;
                            apb_pstrb_o  <= reg_write_i ? reg_wstrb_i : StrbWidth'(0);
                        end else begin
                            // Decode miss: answer directly, never touch the APB side.
                            state       <= StDone;
                            reg_ready_o <= 1'b1;
                            reg_error_o <= 1'b1;
                            reg_rdata_o <= '0;
                        end
                    end
                end
                StSetup: begin
                    state         <= StAccess;
                    apb_penable_o <= 1'b1;
`ifdef CARFIELD_APB_TIMEOUT_EN
                    tmo_cnt       <= '0;
`endif
                end
                StAccess: begin
                    if (sel_pready) begin
                        state         <= StDone;
                        apb_psel_o    <= '0;
                        apb_penable_o <= 1'b0;
                        reg_ready_o   <= 1'b1;
                        reg_rdata_o   <= apb_pwrite_o ? DataWidth'(0) : sel_prdata;
                        reg_error_o   <= sel_pslverr;
                    end
`ifdef CARFIELD_APB_TIMEOUT_EN
                    else if (tmo_cnt == CntWidth'(TimeoutCycles - 1)) begin
                        // Counter would reach TimeoutCycles: abandon the target.
                        state         <= StDone;
                        apb_psel_o    <= '0;
                        apb_penable_o <= 1'b0;
                        reg_ready_o   <= 1'b1;
                        reg_rdata_o   <= '0;
                        reg_error_o   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CntWidth'(1);
                    end
`endif
                end
                StDone: begin
                    state       <= StIdle;
                    reg_ready_o <= 1'b0;
                    reg_rdata_o <= '0;
                    reg_error_o <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carfield_reg_apb_demux.sv
// Self-checking bench for carfield_reg_apb_demux: table of regbus transactions with
// per-target APB responders, a response scoreboard, and hand-written reset sequences.
module tb_carfield_reg_apb_demux;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned N  = 5;
    localparam int unsigned SW = DW / 8;
    localparam int          MaxCycles = 1500;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              reg_valid_i;
    logic              reg_write_i;
    logic [AW-1:0]     reg_addr_i;
    logic [DW-1:0]     reg_wdata_i;
    logic [SW-1:0]     reg_wstrb_i;
    logic              reg_ready_o;
    logic [DW-1:0]     reg_rdata_o;
    logic              reg_error_o;
    logic [N-1:0]      apb_psel_o;
    logic              apb_penable_o;
    logic              apb_pwrite_o;
    logic [AW-1:0]     apb_paddr_o;
    logic [DW-1:0]     apb_pwdata_o;
    logic [SW-1:0]     apb_pstrb_o;
    logic [2:0]        apb_pprot_o;
    logic [N*DW-1:0]   apb_prdata_i;
    logic [N-1:0]      apb_pready_i;
    logic [N-1:0]      apb_pslverr_i;

    carfield_reg_apb_demux dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .reg_valid_i   (reg_valid_i),
        .reg_write_i   (reg_write_i),
        .reg_addr_i    (reg_addr_i),
        .reg_wdata_i   (reg_wdata_i),
        .reg_wstrb_i   (reg_wstrb_i),
        .reg_ready_o   (reg_ready_o),
        .reg_rdata_o   (reg_rdata_o),
        .reg_error_o   (reg_error_o),
        .apb_psel_o    (apb_psel_o),
        .apb_penable_o (apb_penable_o),
        .apb_pwrite_o  (apb_pwrite_o),
        .apb_paddr_o   (apb_paddr_o),
        .apb_pwdata_o  (apb_pwdata_o),
        .apb_pstrb_o   (apb_pstrb_o),
        .apb_pprot_o   (apb_pprot_o),
        .apb_prdata_i  (apb_prdata_i),
        .apb_pready_i  (apb_pready_i),
        .apb_pslverr_i (apb_pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    // One regbus transaction: stimulus plus the response the bench requires.
    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          tgt;       // responding target, -1 = none
        int          wait_cyc;  // ACCESS cycles with pready low before it rises
        bit          slverr;
        logic [31:0] prdata;
        logic [4:0]  exp_psel;  // OR of every psel value seen during the transaction
        int          exp_cyc;   // cycle of reg_ready_o, request presented in cycle 0
        int          exp_acc;   // number of cycles with penable high
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [4:0]  psel;
        int          cyc;
        int          acc;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Selected target follows the vector; all others shout ready+error with junk data.
    task automatic set_targets(input vec_t v, input bit rdy);
        for (int i = 0; i < int'(N); i++) begin
            if (i == v.tgt) begin
                apb_pready_i[i]            = rdy;
                apb_pslverr_i[i]           = v.slverr;
                apb_prdata_i[i*DW +: DW]   = v.prdata;
            end else begin
                apb_pready_i[i]            = 1'b1;
                apb_pslverr_i[i]           = 1'b1;
                apb_prdata_i[i*DW +: DW]   = 32'hDEAD_0000 | 32'(i);
            end
        end
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        exp_t       e;
        exp_t       got;
        int         cyc;
        int         acc;
        logic [4:0] seen;
        bit         done;
        e.psel  = v.exp_psel;
        e.cyc   = v.exp_cyc;
        e.acc   = v.exp_acc;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb.push_back(e);
        cyc  = 0;
        acc  = 0;
        seen = '0;
        done = 1'b0;
        @(negedge clk_i);
        reg_valid_i = 1'b1;
        reg_write_i = v.write;
        reg_addr_i  = v.addr;
        reg_wdata_i = v.wdata;
        reg_wstrb_i = v.wstrb;
        set_targets(v, 1'b0);
        while (!done) begin
            seen |= apb_psel_o;
            if (reg_ready_o) begin
                got = sb.pop_front();
                check($sformatf("%s psel", tag), 64'(seen), 64'(got.psel));
                check($sformatf("%s latency", tag), 64'(cyc), 64'(got.cyc));
                check($sformatf("%s access_cycles", tag), 64'(acc), 64'(got.acc));
                check($sformatf("%s rdata", tag), 64'(reg_rdata_o), 64'(got.rdata));
                check($sformatf("%s error", tag), 64'(reg_error_o), 64'(got.err));
                check($sformatf("%s bus_idle_at_ready", tag), 64'({apb_psel_o, apb_penable_o}), 64'(0));
                reg_valid_i = 1'b0;
                done = 1'b1;
            end else if (cyc >= MaxCycles) begin
                chk_cnt++;
                $display("FAIL %s no_response: got no reg_ready_o, expected it by cycle %0d", tag, v.exp_cyc);
                void'(sb.pop_front());
                reg_valid_i = 1'b0;
                done = 1'b1;
            end else begin
                if (apb_penable_o) begin
                    acc++;
                    if (acc == 1) begin
                        check($sformatf("%s paddr", tag), 64'(apb_paddr_o), 64'(v.addr));
                        check($sformatf("%s pwrite", tag), 64'(apb_pwrite_o), 64'(v.write));
                        check($sformatf("%s pstrb", tag), 64'(apb_pstrb_o), v.write ? 64'(v.wstrb) : 64'(0));
                        if (v.write) check($sformatf("%s pwdata", tag), 64'(apb_pwdata_o), 64'(v.wdata));
                    end
                    set_targets(v, acc > v.wait_cyc);
                end
                @(negedge clk_i);
                cyc++;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s psel", tag), 64'(apb_psel_o), 64'(0));
        check($sformatf("%s penable", tag), 64'(apb_penable_o), 64'(0));
        check($sformatf("%s ready", tag), 64'({reg_ready_o, reg_error_o}), 64'(0));
        check($sformatf("%s rdata", tag), 64'(reg_rdata_o), 64'(0));
        check($sformatf("%s paddr_pwdata", tag), {apb_paddr_o, apb_pwdata_o}, 64'(0));
        check($sformatf("%s pwrite_pstrb_pprot", tag), 64'({apb_pwrite_o, apb_pstrb_o, apb_pprot_o}), 64'(0));
    endtask

    vec_t vecs[13];
    vec_t vr;

    initial begin
        rst_ni        = 1'b0;
        reg_valid_i   = 1'b0;
        reg_write_i   = 1'b0;
        reg_addr_i    = '0;
        reg_wdata_i   = '0;
        reg_wstrb_i   = '0;
        apb_prdata_i  = '0;
        apb_pready_i  = '0;
        apb_pslverr_i = '0;

        //            wr  addr           wdata          wstrb    tgt wait err prdata         psel     cyc  acc  rdata          err
        vecs[0]  = '{1'b0, 32'h2000_4008, 32'h0,         4'hF,    0,  0,   1'b0, 32'hCAFE_0001, 5'b00001, 3,   1,   32'hCAFE_0001, 1'b0};
        vecs[1]  = '{1'b1, 32'h2000_9010, 32'h1234_5678, 4'b0011, 4,  3,   1'b0, 32'h5555_AAAA, 5'b10000, 6,   4,   32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h2000_6000, 32'h0,         4'h0,    -1, 0,   1'b0, 32'h0,         5'b00000, 1,   0,   32'h0,         1'b1};
        vecs[3]  = '{1'b0, 32'h2000_1FFC, 32'h0,         4'h0,    3,  0,   1'b1, 32'hBAD0_0003, 5'b01000, 3,   1,   32'hBAD0_0003, 1'b1};
        vecs[4]  = '{1'b0, 32'h2000_2000, 32'h0,         4'h0,    -1, 0,   1'b0, 32'h0,         5'b00000, 1,   0,   32'h0,         1'b1};
        vecs[5]  = '{1'b0, 32'h2000_5000, 32'h0,         4'hF,    1,  1,   1'b0, 32'hA5A5_0101, 5'b00010, 4,   2,   32'hA5A5_0101, 1'b0};
        vecs[6]  = '{1'b1, 32'h2000_7FFC, 32'hFFFF_0000, 4'hF,    2,  0,   1'b0, 32'h7777_7777, 5'b00100, 3,   1,   32'h0,         1'b0};
        vecs[7]  = '{1'b0, 32'h2000_3FFC, 32'h0,         4'h0,    -1, 0,   1'b0, 32'h0,         5'b00000, 1,   0,   32'h0,         1'b1};
        vecs[8]  = '{1'b0, 32'h2000_4FFF, 32'h0,         4'hF,    0,  2,   1'b0, 32'h0000_4FFF, 5'b00001, 5,   3,   32'h0000_4FFF, 1'b0};
        vecs[9]  = '{1'b0, 32'h2000_A000, 32'h0,         4'h0,    -1, 0,   1'b0, 32'h0,         5'b00000, 1,   0,   32'h0,         1'b1};
        vecs[10] = '{1'b1, 32'h2000_7000, 32'h0BAD_F00D, 4'b1000, 2,  2,   1'b1, 32'h0000_0001, 5'b00100, 5,   3,   32'h0,         1'b1};
        vecs[11] = '{1'b0, 32'h2000_1000, 32'h0,         4'h0,    3,  0,   1'b0, 32'h0CA0_0003, 5'b01000, 3,   1,   32'h0CA0_0003, 1'b0};
`ifdef CARFIELD_APB_TIMEOUT_EN
        vecs[12] = '{1'b0, 32'h2000_7100, 32'h0,         4'h0,    2,  1000, 1'b0, 32'h3333_0002, 5'b00100, 258, 256, 32'h0,        1'b1};
`else
        vecs[12] = '{1'b0, 32'h2000_7100, 32'h0,         4'h0,    2,  1000, 1'b0, 32'h3333_0002, 5'b00100, 1003, 1001, 32'h3333_0002, 1'b0};
`endif

        // Outputs while held in reset.
        repeat (2) @(negedge clk_i);
        check_all_zero("reset_state");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all_zero("after_reset_idle");

        // Table: presented back to back, one request per DONE->IDLE turnaround.
        for (int i = 0; i < 13; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted during ACCESS: outputs clear at once, no response afterwards.
        vr = '{1'b1, 32'h2000_5004, 32'hFACE_0000, 4'hF, 1, 1000, 1'b0, 32'h0, 5'b00010, 0, 0, 32'h0, 1'b0};
        @(negedge clk_i);
        reg_valid_i = 1'b1;
        reg_write_i = vr.write;
        reg_addr_i  = vr.addr;
        reg_wdata_i = vr.wdata;
        reg_wstrb_i = vr.wstrb;
        set_targets(vr, 1'b0);
        repeat (2) @(negedge clk_i);
        check("mid_rst access_phase", 64'({apb_psel_o, apb_penable_o}), 64'({5'b00010, 1'b1}));
        rst_ni      = 1'b0;
        reg_valid_i = 1'b0;
        #1;
        check_all_zero("mid_rst async");
        @(negedge clk_i);
        check_all_zero("mid_rst next_cycle");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        check("mid_rst no_response", 64'({reg_ready_o, apb_psel_o}), 64'(0));

        // A fresh read after reset completes normally.
        run_txn("post_rst_read", vecs[0]);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
